// File: rtl/store_merge_unit.sv
// Memory-stage store path: turns word/halfword/byte stores into full-word writes
// for a data memory without byte enables, using read-modify-write for sub-word stores.
module store_merge_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_MemWriteM,
  input  logic [2:0]               i_MemDataSelM,
  input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  input  logic [DATA_WIDTH-1:0]    i_MemRData,
  output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
  output logic                     o_MemWE,
  output logic [DATA_WIDTH-1:0]    o_MemWData,
  output logic                     o_StallM,
  output logic                     o_AddrErrM
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    MERGE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  state_t state_q, state_d;

  // Sub-word store context captured in IDLE and replayed during RD/MERGE.
  logic [ADDRESS_WIDTH-1:0] word_addr_q;
  logic [1:0]               lane_q;
  size_t                    size_q;
  logic [15:0]              data_q;
  logic                     capture;

  size_t                    req_size;
  logic                     misaligned;
  logic [DATA_WIDTH-1:0]    merged_word;

  // Encodings 5..7 fall back to word so an unexpected select never stalls.
  always_comb begin
    case (i_MemDataSelM)
      3'd1, 3'd2: req_size = SZ_HALF;
      3'd3, 3'd4: req_size = SZ_BYTE;
      default:    req_size = SZ_WORD;
    endcase
  end

  assign misaligned = ((req_size == SZ_HALF) && i_ALUOutM[0]) ||
                      ((req_size == SZ_WORD) && (i_ALUOutM[1:0] != 2'b00));

  // Little-endian lane replacement over the old word returned by the RD cycle.
  always_comb begin
    merged_word = i_MemRData;
    if (size_q == SZ_HALF) begin
      if (lane_q[1]) merged_word[31:16] = data_q;
      else           merged_word[15:0]  = data_q;
    end else begin
      case (lane_q)
        2'd0:    merged_word[7:0]   = data_q[7:0];
        2'd1:    merged_word[15:8]  = data_q[7:0];
        2'd2:    merged_word[23:16] = data_q[7:0];
        default: merged_word[31:24] = data_q[7:0];
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the latched context is cleared on reset even though it is only read
  // after a fresh capture, so an aborted sequence leaves nothing stale behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_addr_q <= '0;
      lane_q      <= '0;
      size_q      <= SZ_WORD;
      data_q      <= '0;
    end else if (capture) begin
      word_addr_q <= {i_ALUOutM[ADDRESS_WIDTH-1:2], 2'b00};
      lane_q      <= i_ALUOutM[1:0];
      size_q      <= req_size;
      data_q      <= i_WriteDataM[15:0];
    end
  end

  // NOTE: every output is given a default before the case so no path through
  // this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    o_MemAddr  = i_ALUOutM;
    o_MemWE    = 1'b0;
    o_MemWData = '0;
    o_StallM   = 1'b0;
    o_AddrErrM = 1'b0;
    capture    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_MemWriteM) begin
          if (misaligned) begin
            o_AddrErrM = 1'b1;
          end else if (req_size == SZ_WORD) begin
            o_MemWE    = 1'b1;
            o_MemWData = i_WriteDataM;
          end else begin
            o_StallM = 1'b1;
            capture  = 1'b1;
            state_d  = RD;
          end
        end
      end

      RD: begin
        o_MemAddr = word_addr_q;
        o_StallM  = 1'b1;
        state_d   = MERGE;
      end

      MERGE: begin
        // Stall drops here so the pipeline retires the store on this edge.
        o_MemAddr  = word_addr_q;
        o_MemWE    = 1'b1;
        o_MemWData = merged_word;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed scenarios plus random
// loads/stores compared against a byte-level memory reference model.
module tb_store_merge_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_MemWriteM;
  logic [2:0]  i_MemDataSelM;
  logic [31:0] i_ALUOutM;
  logic [31:0] i_WriteDataM;
  logic [31:0] i_MemRData;
  logic [31:0] o_MemAddr;
  logic        o_MemWE;
  logic [31:0] o_MemWData;
  logic        o_StallM;
  logic        o_AddrErrM;

  int checks   = 0;
  int failures = 0;

  store_merge_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_MemWriteM   (i_MemWriteM),
    .i_MemDataSelM (i_MemDataSelM),
    .i_ALUOutM     (i_ALUOutM),
    .i_WriteDataM  (i_WriteDataM),
    .i_MemRData    (i_MemRData),
    .o_MemAddr     (o_MemAddr),
    .o_MemWE       (o_MemWE),
    .o_MemWData    (o_MemWData),
    .o_StallM      (o_StallM),
    .o_AddrErrM    (o_AddrErrM)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Word-wide synchronous-read data memory driven by the DUT.
  logic [31:0] mem [0:1023];
  logic        mem_clear;
  always @(posedge i_clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (o_MemWE) begin
      mem[o_MemAddr[11:2]] <= o_MemWData;
    end
    i_MemRData <= mem[o_MemAddr[11:2]];
  end

  // Reference memory, updated byte-by-byte from the store semantics.
  logic [31:0] model_mem [0:1023];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one store; returns the number of cycles o_StallM was high.
  task automatic do_store(input logic [2:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, output int stalls);
    bit          is_half, is_byte, mis;
    logic [31:0] waddr, old_word, exp_word;
    logic [7:0]  b [4];
    int          lane;
    is_half  = (sel == 3'd1) || (sel == 3'd2);
    is_byte  = (sel == 3'd3) || (sel == 3'd4);
    mis      = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
    waddr    = {addr[31:2], 2'b00};
    old_word = model_mem[addr[11:2]];
    for (int i = 0; i < 4; i++) b[i] = old_word[8*i +: 8];
    lane = int'(addr[1:0]);
    if (is_byte) begin
      b[lane] = data[7:0];
    end else if (is_half) begin
      b[lane & 2]     = data[7:0];
      b[(lane & 2)+1] = data[15:8];
    end
    exp_word = {b[3], b[2], b[1], b[0]};
    stalls = 0;

    i_MemWriteM   = 1'b1;
    i_MemDataSelM = sel;
    i_ALUOutM     = addr;
    i_WriteDataM  = data;
    @(negedge i_clk);

    if (mis) begin
      check("mis_err", {31'b0, o_AddrErrM}, 32'd1);
      check("mis_we", {31'b0, o_MemWE}, 32'd0);
      check("mis_stall", {31'b0, o_StallM}, 32'd0);
      @(posedge i_clk);
      #1 i_MemWriteM = 1'b0;
      #1 check("mis_err_pulse", {31'b0, o_AddrErrM}, 32'd0);
    end else if (!is_half && !is_byte) begin
      check("sw_we", {31'b0, o_MemWE}, 32'd1);
      check("sw_addr", o_MemAddr, addr);
      check("sw_wdata", o_MemWData, data);
      check("sw_stall", {31'b0, o_StallM}, 32'd0);
      model_mem[addr[11:2]] = data;
      @(posedge i_clk);
      #1 i_MemWriteM = 1'b0;
    end else begin
      check("sub_idle_we", {31'b0, o_MemWE}, 32'd0);
      check("sub_idle_err", {31'b0, o_AddrErrM}, 32'd0);
      if (o_StallM) stalls++;
      for (int cyc = 0; cyc < 8; cyc++) begin
        @(posedge i_clk);
        // The unit must ignore inputs once the sequence has started.
        #1;
        i_MemDataSelM = 3'($urandom);
        i_ALUOutM     = $urandom;
        i_WriteDataM  = $urandom;
        @(negedge i_clk);
        if (!o_StallM) break;
        stalls++;
        check("sub_rd_we", {31'b0, o_MemWE}, 32'd0);
        check("sub_rd_addr", o_MemAddr, waddr);
      end
      if (o_StallM) begin
        check("sub_timeout", 32'd1, 32'd0);
      end else begin
        check("sub_stalls", stalls, 32'd2);
        check("merge_rdata", i_MemRData, old_word);
        check("merge_we", {31'b0, o_MemWE}, 32'd1);
        check("merge_addr", o_MemAddr, waddr);
        check("merge_wdata", o_MemWData, exp_word);
      end
      model_mem[addr[11:2]] = exp_word;
      @(posedge i_clk);
      #1 i_MemWriteM = 1'b0;
    end
  endtask

  task automatic do_load(input logic [31:0] addr);
    i_MemWriteM   = 1'b0;
    i_MemDataSelM = 3'($urandom);
    i_ALUOutM     = addr;
    i_WriteDataM  = $urandom;
    @(negedge i_clk);
    check("ld_addr", o_MemAddr, addr);
    check("ld_we", {31'b0, o_MemWE}, 32'd0);
    check("ld_stall", {31'b0, o_StallM}, 32'd0);
    check("ld_err", {31'b0, o_AddrErrM}, 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int s1, s2, bad, we_seen;
    logic [2:0]  sel;
    logic [31:0] addr;

    i_rst_n       = 1'b0;
    mem_clear     = 1'b1;
    i_MemWriteM   = 1'b0;
    i_MemDataSelM = 3'd0;
    i_ALUOutM     = 32'h0000_1234;
    i_WriteDataM  = 32'hCAFE_F00D;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;

    @(negedge i_clk);
    check("rst_we", {31'b0, o_MemWE}, 32'd0);
    check("rst_stall", {31'b0, o_StallM}, 32'd0);
    check("rst_err", {31'b0, o_AddrErrM}, 32'd0);
    check("rst_wdata", o_MemWData, 32'd0);
    check("rst_addr", o_MemAddr, 32'h0000_1234);
    @(posedge i_clk);
    #1 mem_clear = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Word store, zero latency.
    do_store(3'd0, 32'h100, 32'hDEADBEEF, s1);
    check("sw_nostall", s1, 32'd0);

    // Byte store into lane 2 of a preloaded word.
    do_store(3'd0, 32'h200, 32'h11223344, s1);
    do_store(3'd3, 32'h202, 32'h000000AB, s1);
    @(negedge i_clk);
    check("sb_lane2_mem", mem[32'h200 >> 2], 32'h11AB3344);

    // Halfword store into the upper lane.
    do_store(3'd0, 32'h200, 32'h11223344, s1);
    do_store(3'd1, 32'h202, 32'hFFFFBEEF, s1);
    @(negedge i_clk);
    check("sh_upper_mem", mem[32'h200 >> 2], 32'hBEEF3344);

    // Misaligned halfword and word.
    do_store(3'd2, 32'h201, 32'h1234, s1);
    do_store(3'd0, 32'h102, 32'h5678, s1);
    @(negedge i_clk);
    check("mis_no_write", mem[32'h100 >> 2], 32'hDEADBEEF);

    // Back-to-back byte stores to a zeroed word.
    @(posedge i_clk);
    #1;
    do_store(3'd3, 32'h300, 32'h55, s1);
    do_store(3'd4, 32'h301, 32'h66, s2);
    check("b2b_cycles", (s1 + 1) + (s2 + 1), 32'd6);
    check("b2b_stalls", s1 + s2, 32'd4);
    @(negedge i_clk);
    check("b2b_mem", mem[32'h300 >> 2], 32'h00006655);

    // Reset asserted while the read cycle is in flight.
    @(posedge i_clk);
    #1;
    i_MemWriteM   = 1'b1;
    i_MemDataSelM = 3'd3;
    i_ALUOutM     = 32'h3F1;
    i_WriteDataM  = 32'h77;
    @(posedge i_clk);
    #1;
    check("rstrd_in_rd", {31'b0, o_StallM}, 32'd1);
    i_rst_n     = 1'b0;
    i_MemWriteM = 1'b0;
    #1;
    check("rstrd_stall", {31'b0, o_StallM}, 32'd0);
    check("rstrd_we", {31'b0, o_MemWE}, 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      if (o_MemWE || o_StallM) we_seen++;
    end
    check("rstrd_quiet", we_seen, 32'd0);
    check("rstrd_mem", mem[32'h3F0 >> 2], model_mem[32'h3F0 >> 2]);
    @(posedge i_clk);
    #1;

    // Random mix of loads and stores of every encoding.
    for (int n = 0; n < 300; n++) begin
      addr = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) == 0) begin
        do_load(addr);
      end else begin
        sel = 3'($urandom_range(0, 7));
        // Bias toward aligned accesses so most stores reach memory.
        if ($urandom_range(0, 3) != 0) begin
          if (sel == 3'd1 || sel == 3'd2) addr[0] = 1'b0;
          else if (!(sel == 3'd3 || sel == 3'd4)) addr[1:0] = 2'b00;
        end
        do_store(sel, addr, $urandom, s1);
      end
    end

    @(negedge i_clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== model_mem[i]) bad++;
    check("final_mem", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Memory-stage store path. It is the write-direction counterpart of the write-back load extraction, which selects and sign- or zero-extends sub-word read data.
- Converts word, halfword and byte stores into full-word writes for the word-wide data memory, which has no byte enables.
- Sub-word stores use a read-modify-write sequence and stall the pipeline while it runs. Word stores and loads pass through with no added latency.

Parameters:
- DATA_WIDTH, 32, data word width. Fixed at 32 because lane logic assumes 4 bytes.
- ADDRESS_WIDTH, 32, byte address width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_MemWriteM  input  1  store request in M stage.
- i_MemDataSelM  input  3  access size: 0 word; 1 or 2 halfword; 3 or 4 byte; 5 to 7 treated as word.
- i_ALUOutM  input  ADDRESS_WIDTH  byte address.
- i_WriteDataM  input  DATA_WIDTH  store data, right-justified.
- i_MemRData  input  DATA_WIDTH  memory read data, valid one cycle after the address is presented (synchronous read).
- o_MemAddr  output  ADDRESS_WIDTH  address to memory.
- o_MemWE  output  1  memory write enable.
- o_MemWData  output  DATA_WIDTH  word to write.
- o_StallM  output  1  freezes F/D/E/M registers and bubbles W.
- o_AddrErrM  output  1  misaligned-store flag, one-cycle pulse.

Behaviour:
- FSM states: IDLE, RD, MERGE. Reset (asynchronous, i_rst_n=0) forces IDLE and clears all latched address, data, size and lane registers.
- Reset values: o_MemWE=0, o_StallM=0, o_AddrErrM=0, o_MemWData=0, o_MemAddr=i_ALUOutM (pass-through in IDLE).
- Lane rule (little-endian): byte lane = addr[1:0]; halfword lane = addr[1]; word = all lanes.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - o_AddrErrM=1 combinationally.
  - o_MemWE=0, no stall, state stays IDLE.
- IDLE, no store: o_MemAddr=i_ALUOutM, o_MemWE=0. This is the load path.
- IDLE, aligned word store:
  - o_MemWE=1, o_MemAddr=i_ALUOutM, o_MemWData=i_WriteDataM.
  - Zero added latency; stays IDLE.
- IDLE, aligned sub-word store:
  - o_StallM=1, o_MemWE=0.
  - Latch word address {addr[31:2],2'b00}, addr[1:0], size, and data.
  - Next state RD.
- RD:
  - o_MemAddr=latched word address, o_MemWE=0, o_StallM=1.
  - Next state MERGE unconditionally.
- MERGE:
  - i_MemRData holds the old word.
  - o_MemWData = old word with the selected lane(s) replaced by the low 8 or 16 bits of the latched data.
  - o_MemWE=1, o_MemAddr=latched word address.
  - o_StallM=0, so the store retires at this edge.
  - Next state IDLE.
- Inputs are ignored in RD and MERGE; the stall holds them stable anyway.
- Sub-word store latency: 3 cycles total, including 2 stall cycles.
- Back-to-back sub-word stores: the second is recognised in the IDLE cycle after MERGE. No bubble beyond its own sequence.
- Reset asserted in RD or MERGE: immediately IDLE, o_MemWE=0, no partial write, latched state discarded.
- An external stall from the hazard unit is out of scope. The M register only advances when o_StallM=0.

Test Plan:
- Reset mid-RD: sb in flight, i_rst_n pulsed low during RD -> o_MemWE never asserted, state IDLE, o_StallM=0 after release.
- Word store: sel=0, addr=0x100, data=0xDEADBEEF -> same cycle o_MemWE=1, o_MemWData=0xDEADBEEF, o_StallM=0.
- Byte store, lane 2: memory word 0x11223344 at 0x200; sel=3, addr=0x202, data=0x000000AB.
  - Stall for 2 cycles.
  - MERGE cycle writes 0x11AB3344 to 0x200.
- Halfword store, upper lane: memory 0x11223344; sel=1, addr=0x202, data=0xFFFFBEEF -> writes 0xBEEF3344 after 2 stall cycles.
- Misaligned accesses: sh to 0x201, and sw to 0x102 -> o_AddrErrM=1 for one cycle, o_MemWE=0, o_StallM=0.
- Back-to-back bytes: sb 0x55 to 0x300, then sb 0x66 to 0x301, memory initially 0 -> final word 0x00006655, 6 cycles total, 4 stall cycles. Reading in the second RD returns 0x00000055 (read-after-write correct).
